quotient_otf_converter: RTL and testbench
=========================================

QUOTIENT_OTF_CONVERTER -- requirements
Module: quotient_otf_converter

Interface
REQ-001 SHALL have parameter NDIGITS, default 16, number of radix-2 signed quotient digits per conversion.
REQ-002 SHALL have parameter CNT_W, default 5, digit counter width; SHALL satisfy 2^CNT_W > NDIGITS.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 async_clear_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse; begins a new conversion.
REQ-006 q_valid  input  1  q_value carries a digit this cycle.
REQ-007 q_value  input  2  signed digit: 2'b10 = +1, 2'b01 = -1, 2'b00 = 0, 2'b11 = illegal.
REQ-008 q_ready  output  1  converter accepts a digit this cycle.
REQ-009 quotient  output  NDIGITS+1  two's-complement conventional quotient.
REQ-010 quot_valid  output  1  quotient is final.
REQ-011 quot_ready  input  1  consumer accepts quotient.
REQ-012 busy  output  1  conversion in progress.
REQ-013 digit_cnt  output  CNT_W  digits accepted in the current conversion.
REQ-014 illegal_digit  output  1  sticky flag: a 2'b11 digit was accepted.

Function
REQ-015 SHALL implement FSM states IDLE, CONV, DONE.
REQ-016 IDLE: start -> load Q=0, QM=all ones (-1), digit_cnt=0, illegal_digit=0, go to CONV next cycle.
REQ-017 CONV: q_ready=1 and busy=1; a digit is accepted on each cycle with q_valid=1.
REQ-018 SHALL, for each accepted digit d, update Q and QM in that same clock edge:
- d=+1: Q <= {Q,1}, QM <= {Q,0}
- d=0: Q <= {Q,0}, QM <= {QM,1}
- d=-1: Q <= {QM,1}, QM <= {QM,0}
- All shifts truncate to NDIGITS+1 bits.
REQ-019 SHALL treat an accepted 2'b11 digit as 0 and set illegal_digit; the flag holds until the next start or reset.
REQ-020 SHALL increment digit_cnt by 1 per accepted digit; the first accepted digit is the MSD.
REQ-021 On acceptance of digit number NDIGITS, SHALL go to DONE; quot_valid=1 on the following cycle, with quotient = Q.
REQ-022 Latency: from the last digit edge to quot_valid high SHALL be exactly 1 cycle.
REQ-023 DONE: quot_valid SHALL stay high and quotient stable until quot_ready=1; then go to IDLE, and quot_valid SHALL drop the next cycle.
REQ-024 quotient SHALL always show Q; it is meaningful only while quot_valid=1.
REQ-025 start in CONV SHALL abort the conversion and reinitialise as in REQ-016; a q_valid digit in the same cycle is discarded.
REQ-026 start in DONE SHALL be ignored.
REQ-027 start and quot_ready together in DONE SHALL go to IDLE only; start is not latched.
REQ-028 q_valid in IDLE or DONE SHALL be ignored, with q_ready=0 in those states.
REQ-029 q_valid low in CONV SHALL hold Q, QM and digit_cnt (stall).
REQ-030 Result SHALL equal sum of d_i * 2^(NDIGITS-1-i), range -(2^NDIGITS - 1) to +(2^NDIGITS - 1), with no overflow.

Reset
REQ-031 async_clear_n=0 SHALL immediately force state=IDLE, Q=0, QM=all ones, digit_cnt=0, quotient=0, quot_valid=0, q_ready=0, busy=0, illegal_digit=0.
REQ-032 Reset mid-conversion SHALL discard the partial result; no quot_valid SHALL follow.
REQ-033 Reset deassertion SHALL take effect at the next rising clk; first start is accepted on that edge or later.

Verification (NDIGITS=4)
REQ-034 start; digits +1,0,-1,+1 on consecutive cycles -> quot_valid one cycle after the 4th digit; quotient=5'b00111 (7); illegal_digit=0.
REQ-035 start; digits -1,-1,-1,-1 -> quotient=5'b10001 (-15); +1,+1,+1,+1 -> 5'b01111 (15).
REQ-036 start; digits +1, gap of 3 cycles with q_valid=0, then 0,0,-1 -> quotient=5'b00111 (7); digit_cnt holds 1 during the gap.
REQ-037 start; digits +1, 2'b11, 0, 0 -> quotient=5'b01000 (8); illegal_digit=1 until the next start.
REQ-038 Hold quot_ready=0 for 5 cycles in DONE -> quot_valid and quotient stable; pulse start there -> ignored; quot_ready=1 -> IDLE, quot_valid low next cycle.
REQ-039 Mid-conversion cases:
- start after 2 digits, then digits 0,0,0,+1 -> quotient=5'b00001.
- async_clear_n low after 2 digits -> all outputs 0, no quot_valid.

Source files
------------

// File: rtl/quotient_otf_converter.sv
// quotient_otf_converter: on-the-fly conversion of radix-2 signed quotient digits
// (MSD first) into a two's-complement quotient using the Q / Q-minus-one register pair.
module quotient_otf_converter #(
    parameter int NDIGITS = 16,
    parameter int CNT_W   = 5
) (
    input  logic               clk,
    input  logic               async_clear_n,
    input  logic               start,
    input  logic               q_valid,
    input  logic [1:0]         q_value,
    output logic               q_ready,
    output logic [NDIGITS:0]   quotient,
    output logic               quot_valid,
    input  logic               quot_ready,
    output logic               busy,
    output logic [CNT_W-1:0]   digit_cnt,
    output logic               illegal_digit
);
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIGITS);

    state_t           state, state_nx;
    logic [NDIGITS:0] q, qm, q_nx, qm_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             ill, ill_nx;

    always_ff @(posedge clk or negedge async_clear_n) begin
        if (!async_clear_n) begin
            state <= IDLE;
            q     <= '0;
            qm    <= '1;
            cnt   <= '0;
            ill   <= 1'b0;
        end else begin
            state <= state_nx;
            q     <= q_nx;
            qm    <= qm_nx;
            cnt   <= cnt_nx;
            ill   <= ill_nx;
        end
    end

    always_comb begin
        state_nx = state;
        q_nx     = q;
        qm_nx    = qm;
        cnt_nx   = cnt;
        ill_nx   = ill;
        // start (re)initialises from IDLE or CONV; DONE waits for the consumer only
        if (start && state != DONE) begin
            state_nx = CONV;
            q_nx     = '0;
            qm_nx    = '1;
            cnt_nx   = '0;
            ill_nx   = 1'b0;
        end else begin
            case (state)
                CONV: if (q_valid) begin
                    case (q_value)
                        2'b10: begin
                            q_nx  = {q[NDIGITS-1:0], 1'b1};
                            qm_nx = {q[NDIGITS-1:0], 1'b0};
                        end
                        2'b01: begin
                            q_nx  = {qm[NDIGITS-1:0], 1'b1};
                            qm_nx = {qm[NDIGITS-1:0], 1'b0};
                        end
                        default: begin
                            q_nx  = {q[NDIGITS-1:0], 1'b0};
                            qm_nx = {qm[NDIGITS-1:0], 1'b1};
                        end
                    endcase
                    ill_nx = ill | (q_value == 2'b11);
                    cnt_nx = CNT_W'(cnt + 1'b1);
                    state_nx = (cnt_nx == LAST) ? DONE : CONV;
                end
                DONE: state_nx = quot_ready ? IDLE : DONE;
                default: state_nx = state;
            endcase
        end
    end

    assign q_ready       = (state == CONV);
    assign busy          = (state == CONV);
    assign quot_valid    = (state == DONE);
    assign quotient      = q;
    assign digit_cnt     = cnt;
    assign illegal_digit = ill;
endmodule

// File: tb/tb_quotient_otf_converter.sv
// tb_quotient_otf_converter: directed digit streams with hand-computed quotients;
// a scoreboard queue is filled by the stimulus and drained by an output monitor.
module tb_quotient_otf_converter;
    localparam int N = 4;

    typedef struct {
        logic [N:0] q;
        logic       ill;
        int         cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         async_clear_n = 1'b0;
    logic         start = 1'b0;
    logic         q_valid = 1'b0;
    logic [1:0]   q_value = 2'b00;
    logic         quot_ready = 1'b1;
    logic         q_ready, quot_valid, busy, illegal_digit;
    logic [N:0]   quotient;
    logic [2:0]   digit_cnt;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic prev_valid = 1'b0;

    quotient_otf_converter #(.NDIGITS(N), .CNT_W(3)) dut (
        .clk(clk),
        .async_clear_n(async_clear_n),
        .start(start),
        .q_valid(q_valid),
        .q_value(q_value),
        .q_ready(q_ready),
        .quotient(quotient),
        .quot_valid(quot_valid),
        .quot_ready(quot_ready),
        .busy(busy),
        .digit_cnt(digit_cnt),
        .illegal_digit(illegal_digit)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: each rising quot_valid must match the oldest expected result.
    always @(negedge clk) begin
        if (!async_clear_n) begin
            prev_valid <= 1'b0;
        end else begin
            if (quot_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_quot_valid", 32'd1, 32'd0);
                end else begin
                    chk("quotient", 32'(quotient), 32'(exp_q[0].q));
                    chk("illegal_digit", 32'(illegal_digit), 32'(exp_q[0].ill));
                    chk("valid_latency_cycle", 32'(cyc), 32'(exp_q[0].cyc));
                    void'(exp_q.pop_front());
                end
            end
            prev_valid <= quot_valid;
        end
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("conv_busy", 32'(busy), 32'd1);
        chk("conv_q_ready", 32'(q_ready), 32'd1);
        chk("conv_cnt0", 32'(digit_cnt), 32'd0);
    endtask

    task automatic send_digit(input logic [1:0] d);
        q_valid = 1'b1;
        q_value = d;
        @(negedge clk);
        q_valid = 1'b0;
    endtask

    // Drives the final digits of a conversion and records the expected result.
    task automatic feed(input int n, input logic [7:0] ds, input logic [N:0] eq, input logic eill);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) begin
                e.q = eq;
                e.ill = eill;
                e.cyc = cyc + 1;
                exp_q.push_back(e);
            end
            send_digit(ds[7 - 2*i -: 2]);
        end
    endtask

    initial begin
        #2;
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_quot_valid", 32'(quot_valid), 32'd0);
        chk("rst_q_ready", 32'(q_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_digit_cnt", 32'(digit_cnt), 32'd0);
        chk("rst_illegal", 32'(illegal_digit), 32'd0);
        @(negedge clk);
        async_clear_n = 1'b1;
        @(negedge clk);

        // +1,0,-1,+1 -> 7
        do_start();
        feed(4, 8'b10_00_01_10, 5'b00111, 1'b0);
        chk("done_cnt4", 32'(digit_cnt), 32'd4);
        chk("done_busy0", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);

        // all -1 -> -15, all +1 -> 15
        do_start();
        feed(4, 8'b01_01_01_01, 5'b10001, 1'b0);
        repeat (2) @(negedge clk);
        do_start();
        feed(4, 8'b10_10_10_10, 5'b01111, 1'b0);
        repeat (2) @(negedge clk);

        // +1, 3-cycle stall, 0,0,-1 -> 7
        do_start();
        send_digit(2'b10);
        for (int i = 0; i < 3; i++) begin
            chk("stall_cnt", 32'(digit_cnt), 32'd1);
            @(negedge clk);
        end
        feed(3, 8'b00_00_01_00, 5'b00111, 1'b0);
        repeat (2) @(negedge clk);

        // +1, illegal, 0, 0 -> 8 with sticky flag
        do_start();
        feed(4, 8'b10_11_00_00, 5'b01000, 1'b1);
        repeat (2) @(negedge clk);
        chk("illegal_sticky_idle", 32'(illegal_digit), 32'd1);

        // abort after 2 digits, restart with 0,0,0,+1 -> 1
        do_start();
        chk("illegal_cleared", 32'(illegal_digit), 32'd0);
        send_digit(2'b10);
        send_digit(2'b10);
        chk("abort_cnt2", 32'(digit_cnt), 32'd2);
        do_start();
        feed(4, 8'b00_00_00_10, 5'b00001, 1'b0);
        repeat (2) @(negedge clk);

        // DONE held by backpressure, start ignored there
        quot_ready = 1'b0;
        do_start();
        feed(4, 8'b10_10_10_10, 5'b01111, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(quot_valid), 32'd1);
            chk("hold_quotient", 32'(quotient), 32'h0f);
            start = (i == 2);
            @(negedge clk);
        end
        start = 1'b0;
        chk("start_in_done_ignored", 32'(busy), 32'd0);
        chk("hold_cnt", 32'(digit_cnt), 32'd4);
        start = 1'b1;
        quot_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("release_valid_low", 32'(quot_valid), 32'd0);
        chk("release_no_restart", 32'(busy), 32'd0);
        @(negedge clk);

        // async clear mid-conversion
        do_start();
        send_digit(2'b10);
        send_digit(2'b01);
        #2;
        async_clear_n = 1'b0;
        #1;
        chk("clr_quotient", 32'(quotient), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_q_ready", 32'(q_ready), 32'd0);
        chk("clr_cnt", 32'(digit_cnt), 32'd0);
        chk("clr_valid", 32'(quot_valid), 32'd0);
        repeat (2) @(negedge clk);
        async_clear_n = 1'b1;
        repeat (6) @(negedge clk);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
